// File: rtl/styler_scan_sequencer.sv
// Scan sequencer for the text styler: walks row/scanline/col, fetches each cell's
// glyph row and attributes, and hands them to the styler datapath over valid/ready.
module styler_scan_sequencer #(
    parameter int COLS  = 80,
    parameter int ROWS  = 25,
    parameter int LINES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_start,
    output logic        fetch_req,
    output logic [5:0]  fetch_row,
    output logic [6:0]  fetch_col,
    input  logic        fetch_ack,
    input  logic [15:0] fetch_bitmap,
    input  logic [24:0] fetch_attr,
    input  logic [5:0]  cursor_row,
    input  logic [6:0]  cursor_col,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  out_scanline,
    output logic [15:0] out_bitmap,
    output logic [24:0] out_attr,
    output logic        out_cursor,
    output logic        faint_phase,
    output logic        blink_phase,
    output logic        cursor_phase,
    output logic        busy,
    output logic        frame_done
);

    typedef enum logic [1:0] {IDLE, FETCH, EMIT, ADVANCE} state_t;

    state_t      state_q, state_d;
    logic [5:0]  row_q, row_d;
    logic [3:0]  line_q, line_d;
    logic [6:0]  col_q, col_d;
    logic [5:0]  cur_row_q, cur_row_d;
    logic [6:0]  cur_col_q, cur_col_d;
    logic [15:0] bitmap_q, bitmap_d;
    logic [24:0] attr_q, attr_d;
    logic [5:0]  frame_cnt_q, frame_cnt_d;
    logic        done_q, done_d;
    logic        last_col, last_line, last_row;

    assign last_col  = (col_q  == 7'(COLS - 1));
    assign last_line = (line_q == 4'(LINES - 1));
    assign last_row  = (row_q  == 6'(ROWS - 1));

    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        line_d      = line_q;
        col_d       = col_q;
        cur_row_d   = cur_row_q;
        cur_col_d   = cur_col_q;
        bitmap_d    = bitmap_q;
        attr_d      = attr_q;
        frame_cnt_d = frame_cnt_q;
        done_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (frame_start) begin
                    row_d     = '0;
                    line_d    = '0;
                    col_d     = '0;
                    cur_row_d = cursor_row;
                    cur_col_d = cursor_col;
                    state_d   = FETCH;
                end
            end
            FETCH: begin
                if (fetch_ack) begin
                    bitmap_d = fetch_bitmap;
                    attr_d   = fetch_attr;
                    state_d  = EMIT;
                end
            end
            EMIT: begin
                if (out_ready) begin
                    state_d = ADVANCE;
                end
            end
            ADVANCE: begin
                // Final cell of the frame: counters stay put, the frame is closed out.
                if (last_col && last_line && last_row) begin
                    done_d      = 1'b1;
                    frame_cnt_d = frame_cnt_q + 6'd1;
                    state_d     = IDLE;
                end else begin
                    state_d = FETCH;
                    if (!last_col) begin
                        col_d = col_q + 7'd1;
                    end else begin
                        col_d = '0;
                        if (!last_line) begin
                            line_d = line_q + 4'd1;
                        end else begin
                            line_d = '0;
                            row_d  = row_q + 6'd1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            row_q       <= '0;
            line_q      <= '0;
            col_q       <= '0;
            cur_row_q   <= '0;
            cur_col_q   <= '0;
            bitmap_q    <= '0;
            attr_q      <= '0;
            frame_cnt_q <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            line_q      <= line_d;
            col_q       <= col_d;
            cur_row_q   <= cur_row_d;
            cur_col_q   <= cur_col_d;
            bitmap_q    <= bitmap_d;
            attr_q      <= attr_d;
            frame_cnt_q <= frame_cnt_d;
            done_q      <= done_d;
        end
    end

    assign busy         = (state_q != IDLE);
    assign fetch_req    = (state_q == FETCH);
    assign out_valid    = (state_q == EMIT);
    assign fetch_row    = row_q;
    assign fetch_col    = col_q;
    assign out_scanline = line_q;
    assign out_bitmap   = bitmap_q;
    assign out_attr     = attr_q;
    // Gated by EMIT so the cleared counters and cursor latch never flag a cursor out of reset.
    assign out_cursor   = (state_q == EMIT) && (row_q == cur_row_q) && (col_q == cur_col_q);
    assign frame_done   = done_q;
    assign faint_phase  = frame_cnt_q[0];
    assign cursor_phase = frame_cnt_q[4];
    assign blink_phase  = frame_cnt_q[5];

endmodule

// File: tb/tb_styler_scan_sequencer.sv
// Randomized bench for styler_scan_sequencer on a 2x2x2 frame, checked against a
// queue of expected cells and a cycle-cost model.
module tb_styler_scan_sequencer;

    localparam int COLS  = 2;
    localparam int ROWS  = 2;
    localparam int LINES = 2;
    localparam int NCELL = COLS * ROWS * LINES;

    typedef struct {
        int r;
        int l;
        int c;
    } cell_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        frame_start = 1'b0;
    logic        fetch_req;
    logic [5:0]  fetch_row;
    logic [6:0]  fetch_col;
    logic        fetch_ack = 1'b0;
    logic [15:0] fetch_bitmap = '0;
    logic [24:0] fetch_attr = '0;
    logic [5:0]  cursor_row = '0;
    logic [6:0]  cursor_col = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [3:0]  out_scanline;
    logic [15:0] out_bitmap;
    logic [24:0] out_attr;
    logic        out_cursor;
    logic        faint_phase, blink_phase, cursor_phase;
    logic        busy, frame_done;

    int vectors = 0;
    int miscompares = 0;
    logic [5:0] fc = '0;

    styler_scan_sequencer #(.COLS(COLS), .ROWS(ROWS), .LINES(LINES)) dut (
        .clk(clk), .rst(rst), .frame_start(frame_start),
        .fetch_req(fetch_req), .fetch_row(fetch_row), .fetch_col(fetch_col),
        .fetch_ack(fetch_ack), .fetch_bitmap(fetch_bitmap), .fetch_attr(fetch_attr),
        .cursor_row(cursor_row), .cursor_col(cursor_col),
        .out_valid(out_valid), .out_ready(out_ready), .out_scanline(out_scanline),
        .out_bitmap(out_bitmap), .out_attr(out_attr), .out_cursor(out_cursor),
        .faint_phase(faint_phase), .blink_phase(blink_phase), .cursor_phase(cursor_phase),
        .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        frame_start = 1'b0;
        fetch_ack = 1'b0;
        out_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        fc = '0;
        step();
    endtask

    task automatic run_frame(input int ack_lo, input int ack_hi, input int rdy_lo, input int rdy_hi,
                             input bit use_fix, input logic [5:0] crow, input logic [6:0] ccol,
                             input bit spam_start, input int abort_at,
                             output int xfers, output int cur_hits);
        cell_t q[$];
        int cyc, waits, ack_wait, ack_d, rdy_wait, rdy_d, fetch_cycles, exp_hits;
        bit prev_fetch, prev_valid, done;
        logic [5:0]  hold_row;
        logic [6:0]  hold_col;
        logic [15:0] cap_bm;
        logic [24:0] cap_at;
        logic [3:0]  s_line;
        logic [15:0] s_bm;
        logic [24:0] s_at;
        logic        s_cur;
        bit          exp_cur;
        exp_hits = 0;
        for (int r = 0; r < ROWS; r++)
            for (int l = 0; l < LINES; l++)
                for (int c = 0; c < COLS; c++) begin
                    q.push_back('{r: r, l: l, c: c});
                    if (r == int'(crow) && c == int'(ccol)) exp_hits++;
                end
        xfers = 0; cur_hits = 0; waits = 0; cyc = 0; done = 0;
        prev_fetch = 0; prev_valid = 0;
        ack_d = 0; ack_wait = 0; rdy_d = 0; rdy_wait = 0; fetch_cycles = 0;
        cap_bm = '0; cap_at = '0; hold_row = '0; hold_col = '0;
        s_line = '0; s_bm = '0; s_at = '0; s_cur = 1'b0;

        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_before_start: busy=%b want 0", busy);
        end
        cursor_row = crow;
        cursor_col = ccol;
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        cursor_row = 6'($urandom);
        cursor_col = 7'($urandom);

        while (!done && cyc < 5000) begin
            if (frame_done === 1'b1) fc = fc + 6'd1;
            vectors++;
            if (fetch_req === 1'b1 && out_valid === 1'b1) begin
                miscompares++;
                $display("FAIL req_valid_exclusive: fetch_req=%b out_valid=%b at cyc %0d", fetch_req, out_valid, cyc);
            end
            vectors++;
            if ({blink_phase, cursor_phase, faint_phase} !== {fc[5], fc[4], fc[0]}) begin
                miscompares++;
                $display("FAIL phases: got b/c/f=%b%b%b want %b%b%b", blink_phase, cursor_phase, faint_phase, fc[5], fc[4], fc[0]);
            end
            fetch_ack = 1'($urandom);
            fetch_bitmap = 16'($urandom);
            fetch_attr = 25'($urandom);
            out_ready = 1'($urandom);
            frame_start = spam_start ? ($urandom_range(0, 3) == 0) : 1'b0;

            if (frame_done === 1'b1) begin
                frame_start = 1'b0;
                done = 1;
                vectors++;
                if (cyc != 3 * NCELL + waits || q.size() != 0 || busy !== 1'b0) begin
                    miscompares++;
                    $display("FAIL frame_done_timing: cyc=%0d left=%0d busy=%b want cyc=%0d left=0 busy=0", cyc, q.size(), busy, 3 * NCELL + waits);
                end
            end else if (fetch_req === 1'b1) begin
                if (!prev_fetch) begin
                    ack_d = $urandom_range(ack_lo, ack_hi);
                    ack_wait = 0;
                    fetch_cycles = 0;
                    hold_row = fetch_row;
                    hold_col = fetch_col;
                    vectors++;
                    if (q.size() == 0 || fetch_row !== 6'(q[0].r) || fetch_col !== 7'(q[0].c)) begin
                        miscompares++;
                        $display("FAIL fetch_addr: got row=%0d col=%0d want row=%0d col=%0d", fetch_row, fetch_col,
                                 q.size() ? q[0].r : -1, q.size() ? q[0].c : -1);
                    end
                end else begin
                    vectors++;
                    if (fetch_row !== hold_row || fetch_col !== hold_col) begin
                        miscompares++;
                        $display("FAIL fetch_addr_stable: got %0d/%0d want %0d/%0d", fetch_row, fetch_col, hold_row, hold_col);
                    end
                end
                fetch_cycles++;
                if (ack_wait == ack_d) begin
                    fetch_ack = 1'b1;
                    cap_bm = use_fix ? 16'hA5C3 : 16'($urandom);
                    cap_at = use_fix ? 25'h1000001 : 25'($urandom);
                    fetch_bitmap = cap_bm;
                    fetch_attr = cap_at;
                    waits += ack_d;
                    vectors++;
                    if (fetch_cycles != ack_d + 1) begin
                        miscompares++;
                        $display("FAIL fetch_hold_len: got %0d cycles want %0d", fetch_cycles, ack_d + 1);
                    end
                end else begin
                    fetch_ack = 1'b0;
                    ack_wait++;
                end
            end else if (out_valid === 1'b1) begin
                if (!prev_valid) begin
                    if (abort_at >= 0 && xfers == abort_at) begin
                        rst = 1'b1;
                        frame_start = 1'b1;
                        return;
                    end
                    exp_cur = (q.size() != 0) && (q[0].r == int'(crow)) && (q[0].c == int'(ccol));
                    rdy_d = $urandom_range(rdy_lo, rdy_hi);
                    rdy_wait = 0;
                    s_line = out_scanline; s_bm = out_bitmap; s_at = out_attr; s_cur = out_cursor;
                    vectors++;
                    if (q.size() == 0 || out_scanline !== 4'(q[0].l) || out_bitmap !== cap_bm ||
                        out_attr !== cap_at || out_cursor !== exp_cur) begin
                        miscompares++;
                        $display("FAIL emit_fields: got line=%0d bm=%h at=%h cur=%b want line=%0d bm=%h at=%h cur=%b",
                                 out_scanline, out_bitmap, out_attr, out_cursor,
                                 q.size() ? q[0].l : -1, cap_bm, cap_at, exp_cur);
                    end
                end else begin
                    vectors++;
                    if (out_scanline !== s_line || out_bitmap !== s_bm || out_attr !== s_at || out_cursor !== s_cur) begin
                        miscompares++;
                        $display("FAIL emit_stable: got line=%0d bm=%h at=%h cur=%b want %0d %h %h %b",
                                 out_scanline, out_bitmap, out_attr, out_cursor, s_line, s_bm, s_at, s_cur);
                    end
                end
                if (rdy_wait == rdy_d) begin
                    out_ready = 1'b1;
                    waits += rdy_d;
                    if (out_cursor === 1'b1) cur_hits++;
                    if (q.size() != 0) void'(q.pop_front());
                    xfers++;
                end else begin
                    out_ready = 1'b0;
                    rdy_wait++;
                end
            end
            prev_fetch = (fetch_req === 1'b1);
            prev_valid = (out_valid === 1'b1);
            if (!done) begin
                step();
                cyc++;
            end
        end
        if (!done) begin
            miscompares++;
            $display("FAIL frame_timeout: no frame_done after %0d cycles", cyc);
        end
        vectors++;
        if (cur_hits != exp_hits) begin
            miscompares++;
            $display("FAIL cursor_hits_model: got %0d want %0d", cur_hits, exp_hits);
        end
        step();
        vectors++;
        if (frame_done !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL done_pulse_width: frame_done=%b busy=%b want 0 0", frame_done, busy);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        vectors++;
        if (fetch_req !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0 ||
            fetch_row !== 6'd0 || fetch_col !== 7'd0 || out_scanline !== 4'd0 || out_bitmap !== 16'd0 ||
            out_attr !== 25'd0 || out_cursor !== 1'b0 || faint_phase !== 1'b0 || blink_phase !== 1'b0 ||
            cursor_phase !== 1'b0) begin
            miscompares++;
            $display("FAIL %s: req=%b vld=%b busy=%b done=%b row=%0d col=%0d line=%0d bm=%h at=%h cur=%b ph=%b%b%b want all 0",
                     tag, fetch_req, out_valid, busy, frame_done, fetch_row, fetch_col, out_scanline,
                     out_bitmap, out_attr, out_cursor, blink_phase, cursor_phase, faint_phase);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        frame_start = 1'b1;
        step();
        step();
        check_reset_outputs("reset_state");
        rst = 1'b0;
        frame_start = 1'b0;
        fc = '0;
        step();
        vectors++;
        if (busy !== 1'b0 || fetch_req !== 1'b0) begin
            miscompares++;
            $display("FAIL start_during_reset: busy=%b fetch_req=%b want 0 0", busy, fetch_req);
        end
    endtask

    task automatic test_basic_frame();
        int x, h;
        run_frame(0, 0, 0, 0, 0, 6'd63, 7'd127, 0, -1, x, h);
        vectors++;
        if (x != 8) begin
            miscompares++;
            $display("FAIL basic_xfers: got %0d want 8", x);
        end
    endtask

    task automatic test_fetch_wait();
        int x, h;
        run_frame(5, 5, 0, 0, 1, 6'd63, 7'd127, 0, -1, x, h);
    endtask

    task automatic test_ready_stall();
        int x, h;
        run_frame(0, 1, 4, 4, 0, 6'd63, 7'd127, 0, -1, x, h);
    endtask

    task automatic test_cursor();
        int x, h;
        run_frame(0, 2, 0, 2, 0, 6'd1, 7'd0, 0, -1, x, h);
        vectors++;
        if (h != 2) begin
            miscompares++;
            $display("FAIL cursor_count: got %0d want 2", h);
        end
    endtask

    task automatic test_phases();
        int x, h;
        apply_reset();
        for (int f = 0; f < 16; f++) begin
            run_frame(0, 2, 0, 2, 0, 6'($urandom_range(0, ROWS - 1)), 7'($urandom_range(0, COLS - 1)), 1, -1, x, h);
        end
        vectors++;
        if (cursor_phase !== 1'b1 || faint_phase !== 1'b0 || blink_phase !== 1'b0) begin
            miscompares++;
            $display("FAIL phase_after_16: got c/f/b=%b%b%b want 100", cursor_phase, faint_phase, blink_phase);
        end
    endtask

    task automatic test_reset_midframe();
        int x, h;
        apply_reset();
        run_frame(0, 1, 0, 1, 0, 6'd0, 7'd1, 0, -1, x, h);
        run_frame(0, 1, 0, 1, 0, 6'd0, 7'd1, 0, -1, x, h);
        run_frame(0, 1, 0, 1, 0, 6'd0, 7'd1, 0, $urandom_range(1, NCELL - 1), x, h);
        step();
        fc = '0;
        check_reset_outputs("midframe_reset");
        step();
        check_reset_outputs("midframe_reset_hold");
        rst = 1'b0;
        frame_start = 1'b0;
        step();
        vectors++;
        if (busy !== 1'b0 || frame_done !== 1'b0) begin
            miscompares++;
            $display("FAIL abandoned_frame: busy=%b frame_done=%b want 0 0", busy, frame_done);
        end
        run_frame(0, 2, 0, 2, 0, 6'd1, 7'd1, 0, -1, x, h);
        vectors++;
        if (x != NCELL) begin
            miscompares++;
            $display("FAIL restart_xfers: got %0d want %0d", x, NCELL);
        end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_fetch_wait();
        test_ready_stall();
        test_cursor();
        test_phases();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
